cplx_issue_ctrl: RTL and testbench
==================================

CPLX_ISSUE_CTRL -- requirements
Module: cplx_issue_ctrl

Interface
REQ-001 SHALL have parameter ADDR_W, default 5, meaning width of register-file index and PC.
REQ-002 SHALL have parameter WORD_W, default 32, meaning instruction word width.
REQ-003 SHALL have parameter WB_LAT, default 3, meaning cycles from issue to register-file write edge.
REQ-004 SHALL have one clock and a synchronous active-high reset: clk  in  1  rising-edge clock.
REQ-005 rst  in  1  synchronous active-high reset.
REQ-006 start  in  1  begin program execution; sampled only in IDLE.
REQ-007 last_pc  in  ADDR_W  PC of final instruction; sampled with start.
REQ-008 instr  in  WORD_W  combinational memory read data at pc.
REQ-009 pc  out  ADDR_W  instruction memory address.
REQ-010 issue_valid  out  1  issue_instr enters the operand-read stage on this edge.
REQ-011 issue_instr  out  WORD_W  registered instruction to the datapath.
REQ-012 busy  out  1  high in RUN and DRAIN.
REQ-013 done  out  1  one-cycle pulse when the program has fully written back.
REQ-014 stall_cnt  out  8  saturating count of hazard-stall cycles for the last run.

Function
REQ-015 SHALL decode fields as op[31:30], wd1[29:25], wd2[24:20], rs1[19:15], rs2[14:10], rs3[9:5], rs4[4:0].
REQ-016 SHALL implement states IDLE, RUN, DRAIN, DONE.
REQ-017 IDLE: start=1 -> pc<=0, latch last_pc, clear stall_cnt, go to RUN. start=0 -> stay. start in any other state SHALL be ignored.
REQ-018 SHALL keep a 2-entry in-flight shadow (valid, wd1, wd2) shifted every RUN/DRAIN cycle. Slot0 is loaded from the issued word or a bubble. The older slot is retired.
REQ-019 Hazard SHALL be asserted when any rs1..rs4 of instr equals wd1 or wd2 of any valid shadow slot (16 compares).
REQ-020 RUN, no hazard -> issue_valid=1 next cycle with issue_instr=instr; pc<=pc+1.
REQ-021 RUN, hazard -> issue_valid=0; bubble shifted in; pc held; stall_cnt+1, saturating at 255.
REQ-022 Issuing the word at pc==last_pc SHALL go to DRAIN without incrementing pc. No wrap to 0 is allowed.
REQ-023 last_pc=31 SHALL execute all 32 words, with no pc wrap.
REQ-024 DRAIN SHALL last exactly WB_LAT cycles with issue_valid=0, then go to DONE.
REQ-025 DONE SHALL assert done for one cycle, then go to IDLE; busy=0 in DONE.
REQ-026 The result of an instruction issued at edge t SHALL be writable at t+WB_LAT. A dependent instruction SHALL issue no earlier than edge t+WB_LAT.
REQ-027 Sources matching a same-word destination SHALL NOT stall.
REQ-028 Hazard logic SHALL check the shadow contents as they are before the current shift.

Reset
REQ-029 rst SHALL force state=IDLE, pc=0, issue_valid=0, issue_instr=0, busy=0, done=0, stall_cnt=0, and clear all shadow valids.
REQ-030 rst asserted mid-RUN or mid-DRAIN SHALL abort immediately with no done pulse. Reset dominates start.

Structure
REQ-031 Package cplx_pipe_pkg SHALL hold the field offset constants, the opcode encodings (00 add, 01 sub, 1x mult), and the state enum.
REQ-032 The comparator array SHALL be sub-module cplx_hazard_det: inputs are the four sources and the shadow; output is hazard.
REQ-033 All state SHALL be in one clocked process. Hazard and next-state logic SHALL be combinational.

Verification
REQ-034 Independent stream, last_pc=3, no shared regs -> issue_valid high for 4 consecutive cycles; done 3+1 cycles after the last issue; stall_cnt=0.
REQ-035 Back-to-back RAW (word0 wd1=4; word1 rs1=4), last_pc=1 -> word1 issues 3 cycles after word0; stall_cnt=2.
REQ-036 Distance-2 RAW (word0 wd2=7, word1 independent, word2 rs4=7) -> exactly 1 stall before word2.
REQ-037 last_pc=31, all independent -> pc reaches 31 without wrapping to 0; 32 issues; one done pulse.
REQ-038 rst for 1 cycle after the 5th issue -> issue_valid=0 next cycle, no done pulse, busy=0; a subsequent start reruns from pc=0.
REQ-039 start pulsed during RUN and DRAIN -> no restart; pc sequence unaffected.

Source files
------------

// File: rtl/cplx_pipe_pkg.sv
`default_nettype none
// ============================================================================
// Module      : cplx_pipe_pkg
// Description : Shared instruction-field layout, opcode encodings, FSM state
//               enum and in-flight shadow entry type for the issue controller.
// Revision    : 1.0 - initial release
// ============================================================================
package cplx_pipe_pkg;

  // Register index width carried in every instruction field
  localparam int REG_W = 5;

  // Bit offsets of the instruction fields (LSB of each field)
  localparam int OP_MSB  = 31;
  localparam int OP_LSB  = 30;
  localparam int WD1_LSB = 25;
  localparam int WD2_LSB = 20;
  localparam int RS1_LSB = 15;
  localparam int RS2_LSB = 10;
  localparam int RS3_LSB = 5;
  localparam int RS4_LSB = 0;

  // Opcode encodings; any op with bit 1 set is a multiply
  localparam logic [1:0] OP_ADD  = 2'b00;
  localparam logic [1:0] OP_SUB  = 2'b01;
  localparam logic [1:0] OP_MULT = 2'b10;

  // Number of issued words whose results are not yet writable
  localparam int SHADOW_DEPTH = 2;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  typedef struct packed {
    logic             valid;
    logic [REG_W-1:0] wd1;
    logic [REG_W-1:0] wd2;
  } shadow_t;

  // Extract one register-index field starting at bit lsb
  function automatic logic [REG_W-1:0] reg_field(input logic [31:0] word, input int lsb);
    return word[lsb +: REG_W];
  endfunction

endpackage
`default_nettype wire

// File: rtl/cplx_hazard_det.sv
`default_nettype none
// ============================================================================
// Module      : cplx_hazard_det
// Description : Compares the four source indices of the candidate word
//               against both destinations of every valid in-flight entry.
// Revision    : 1.0 - initial release
// ============================================================================
module cplx_hazard_det
  import cplx_pipe_pkg::*;
(
  input  logic [REG_W-1:0]                  rs1_i,
  input  logic [REG_W-1:0]                  rs2_i,
  input  logic [REG_W-1:0]                  rs3_i,
  input  logic [REG_W-1:0]                  rs4_i,
  input  shadow_t [SHADOW_DEPTH-1:0]        shadow_i,
  output logic                              hazard_o
);

  logic [REG_W-1:0]        w_src [4];
  logic [SHADOW_DEPTH-1:0] w_slot_hit;

  assign w_src[0] = rs1_i;
  assign w_src[1] = rs2_i;
  assign w_src[2] = rs3_i;
  assign w_src[3] = rs4_i;

  for (genvar s = 0; s < SHADOW_DEPTH; s++) begin : g_slot
    logic [3:0] w_hit;
    for (genvar r = 0; r < 4; r++) begin : g_src
      assign w_hit[r] = (w_src[r] == shadow_i[s].wd1) | (w_src[r] == shadow_i[s].wd2);
    end
    // A bubble slot never blocks issue
    assign w_slot_hit[s] = shadow_i[s].valid & (|w_hit);
  end

  assign hazard_o = |w_slot_hit;

endmodule
`default_nettype wire

// File: rtl/cplx_issue_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : cplx_issue_ctrl
// Description : In-order issue controller. Fetches words from pc, stalls on
//               read-after-write hazards against in-flight results, drains
//               the pipeline after the last word and pulses done.
// Revision    : 1.0 - initial release
// ============================================================================
module cplx_issue_ctrl
  import cplx_pipe_pkg::*;
#(
  parameter int ADDR_W = 5,
  parameter int WORD_W = 32,
  parameter int WB_LAT = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start_i,
  input  logic [ADDR_W-1:0] last_pc_i,
  input  logic [WORD_W-1:0] instr_i,
  output logic [ADDR_W-1:0] pc_o,
  output logic              issue_valid_o,
  output logic [WORD_W-1:0] issue_instr_o,
  output logic              busy_o,
  output logic              done_o,
  output logic [7:0]        stall_cnt_o
);

  localparam int DRAIN_W = $clog2(WB_LAT + 1);

  state_e                    state_q, state_d;
  logic [ADDR_W-1:0]         pc_q, pc_d;
  logic [ADDR_W-1:0]         last_pc_q, last_pc_d;
  logic                      issue_valid_q, issue_valid_d;
  logic [WORD_W-1:0]         issue_instr_q, issue_instr_d;
  logic [7:0]                stall_cnt_q, stall_cnt_d;
  shadow_t [SHADOW_DEPTH-1:0] shadow_q, shadow_d;
  logic [DRAIN_W-1:0]        drain_cnt_q, drain_cnt_d;

  logic    w_hazard;
  logic    w_issue;
  logic    w_at_last;
  shadow_t w_new_entry;

  // Hazard check sees the shadow as registered, before this cycle's shift
  cplx_hazard_det u_hazard_det (
    .rs1_i    (reg_field(instr_i[31:0], RS1_LSB)),
    .rs2_i    (reg_field(instr_i[31:0], RS2_LSB)),
    .rs3_i    (reg_field(instr_i[31:0], RS3_LSB)),
    .rs4_i    (reg_field(instr_i[31:0], RS4_LSB)),
    .shadow_i (shadow_q),
    .hazard_o (w_hazard)
  );

  assign w_issue           = (state_q == ST_RUN) && !w_hazard;
  assign w_at_last         = (pc_q == last_pc_q);
  assign w_new_entry.valid = 1'b1;
  assign w_new_entry.wd1   = reg_field(instr_i[31:0], WD1_LSB);
  assign w_new_entry.wd2   = reg_field(instr_i[31:0], WD2_LSB);

  // All state registers; reset aborts any run without a done pulse
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      pc_q          <= '0;
      last_pc_q     <= '0;
      issue_valid_q <= 1'b0;
      issue_instr_q <= '0;
      stall_cnt_q   <= '0;
      shadow_q      <= '0;
      drain_cnt_q   <= '0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      last_pc_q     <= last_pc_d;
      issue_valid_q <= issue_valid_d;
      issue_instr_q <= issue_instr_d;
      stall_cnt_q   <= stall_cnt_d;
      shadow_q      <= shadow_d;
      drain_cnt_q   <= drain_cnt_d;
    end
  end

  // Next-state: DRAIN covers the final issue cycle plus WB_LAT quiet cycles
  always_comb begin
    state_d     = state_q;
    drain_cnt_d = drain_cnt_q;
    case (state_q)
      ST_IDLE:  if (start_i) state_d = ST_RUN;
      ST_RUN: begin
        if (w_issue && w_at_last) begin
          state_d     = ST_DRAIN;
          drain_cnt_d = '0;
        end
      end
      ST_DRAIN: begin
        if (drain_cnt_q == DRAIN_W'(WB_LAT)) state_d = ST_DONE;
        else                                  drain_cnt_d = drain_cnt_q + DRAIN_W'(1);
      end
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Datapath next values: pc advance, issue register, shadow shift, stalls
  always_comb begin
    pc_d          = pc_q;
    last_pc_d     = last_pc_q;
    issue_valid_d = 1'b0;
    issue_instr_d = issue_instr_q;
    stall_cnt_d   = stall_cnt_q;
    shadow_d      = shadow_q;
    case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          pc_d        = '0;
          last_pc_d   = last_pc_i;
          stall_cnt_d = '0;
          shadow_d    = '0;
        end
      end
      ST_RUN: begin
        shadow_d[1] = shadow_q[0];
        if (w_issue) begin
          issue_valid_d = 1'b1;
          issue_instr_d = instr_i;
          shadow_d[0]   = w_new_entry;
          // pc stops on the last word so it never wraps
          if (!w_at_last) pc_d = pc_q + ADDR_W'(1);
        end else begin
          shadow_d[0] = '0;
          if (stall_cnt_q != 8'hFF) stall_cnt_d = stall_cnt_q + 8'd1;
        end
      end
      ST_DRAIN: begin
        shadow_d[1] = shadow_q[0];
        shadow_d[0] = '0;
      end
      default: ;
    endcase
  end

  // Status outputs decoded from the current state
  always_comb begin
    busy_o = (state_q == ST_RUN) || (state_q == ST_DRAIN);
    done_o = (state_q == ST_DONE);
  end

  assign pc_o          = pc_q;
  assign issue_valid_o = issue_valid_q;
  assign issue_instr_o = issue_instr_q;
  assign stall_cnt_o   = stall_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_cplx_issue_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_cplx_issue_ctrl
// Description : Self-checking bench. Issue times are predicted from the
//               dependency-distance rule (a consumer issues no earlier than
//               producer issue + WB_LAT, one word per cycle at most).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_cplx_issue_ctrl;

  localparam int ADDR_W = 5;
  localparam int WORD_W = 32;
  localparam int WB_LAT = 3;

  logic              clk = 1'b0;
  logic              rst;
  logic              start_i;
  logic [ADDR_W-1:0] last_pc_i;
  logic [WORD_W-1:0] instr_i;
  logic [ADDR_W-1:0] pc_o;
  logic              issue_valid_o;
  logic [WORD_W-1:0] issue_instr_o;
  logic              busy_o;
  logic              done_o;
  logic [7:0]        stall_cnt_o;

  logic [31:0] mem [32];
  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  assign instr_i = mem[pc_o];

  cplx_issue_ctrl #(
    .ADDR_W (ADDR_W),
    .WORD_W (WORD_W),
    .WB_LAT (WB_LAT)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .start_i       (start_i),
    .last_pc_i     (last_pc_i),
    .instr_i       (instr_i),
    .pc_o          (pc_o),
    .issue_valid_o (issue_valid_o),
    .issue_instr_o (issue_instr_o),
    .busy_o        (busy_o),
    .done_o        (done_o),
    .stall_cnt_o   (stall_cnt_o)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] mk(input int op, input int wd1, input int wd2,
                                     input int r1, input int r2, input int r3, input int r4);
    logic [31:0] w;
    w = {op[1:0], wd1[4:0], wd2[4:0], r1[4:0], r2[4:0], r3[4:0], r4[4:0]};
    return w;
  endfunction

  // True when word b reads a register that word a writes
  function automatic bit depends(input logic [31:0] a, input logic [31:0] b);
    bit d;
    d = 1'b0;
    for (int s = 0; s < 4; s++) begin
      logic [4:0] src;
      src = b[s*5 +: 5];
      if (src == a[29:25] || src == a[24:20]) d = 1'b1;
    end
    return d;
  endfunction

  // Words whose sources are all r0 and destinations never r0: mutually independent
  task automatic fill_indep(input int n);
    for (int i = 0; i < n; i++)
      mem[i] = mk($urandom_range(0, 3), $urandom_range(1, 31), $urandom_range(1, 31), 0, 0, 0, 0);
  endtask

  task automatic fill_random(input int n);
    for (int i = 0; i < n; i++)
      mem[i] = mk($urandom_range(0, 3), $urandom_range(0, 7), $urandom_range(0, 7),
                  $urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 7));
  endtask

  // Start a run at relative edge 0 and check every following cycle against
  // the predicted issue schedule. rst_issue>0 asserts reset after that many issues.
  task automatic run_prog(input int last, input bit poke_start, input int rst_issue);
    int t_iss [32];
    int tl;
    int nissue;
    bit exp_iv;
    for (int i = 0; i <= last; i++) begin
      t_iss[i] = (i == 0) ? 1 : t_iss[i-1] + 1;
      for (int j = 0; j < i; j++)
        if (depends(mem[j], mem[i]) && t_iss[j] + WB_LAT > t_iss[i]) t_iss[i] = t_iss[j] + WB_LAT;
    end
    tl = t_iss[last];

    @(posedge clk); #1;
    start_i   = 1'b1;
    last_pc_i = last[ADDR_W-1:0];
    @(posedge clk); #1;
    start_i = 1'b0;
    chk("start_pc", 32'(pc_o), 0);
    chk("start_busy", 32'(busy_o), 1);
    chk("start_stall", 32'(stall_cnt_o), 0);

    nissue = 0;
    for (int k = 1; k <= tl + 5; k++) begin
      if (poke_start) start_i = (k < tl + 3) ? 1'($urandom_range(0, 1)) : 1'b0;
      @(posedge clk); #1;
      exp_iv = (nissue <= last) && (t_iss[nissue] == k);
      chk("issue_valid", 32'(issue_valid_o), 32'(exp_iv));
      if (exp_iv) begin
        chk("issue_instr", issue_instr_o, mem[nissue]);
        nissue++;
      end
      chk("pc", 32'(pc_o), (nissue > last) ? last : nissue);
      chk("busy", 32'(busy_o), 32'(k < tl + 4));
      chk("done", 32'(done_o), 32'(k == tl + 4));
      if (rst_issue > 0 && nissue == rst_issue && exp_iv) begin
        start_i = 1'b0;
        rst     = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("abort_valid", 32'(issue_valid_o), 0);
        chk("abort_busy", 32'(busy_o), 0);
        chk("abort_pc", 32'(pc_o), 0);
        chk("abort_stall", 32'(stall_cnt_o), 0);
        for (int q = 0; q < 8; q++) begin
          @(posedge clk); #1;
          chk("abort_no_done", 32'(done_o), 0);
          chk("abort_idle", 32'(busy_o), 0);
        end
        return;
      end
    end
    chk("stall_cnt", 32'(stall_cnt_o), tl - last - 1);
  endtask

  initial begin
    rst       = 1'b1;
    start_i   = 1'b1;
    last_pc_i = '0;
    for (int i = 0; i < 32; i++) mem[i] = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_pc", 32'(pc_o), 0);
    chk("rst_valid", 32'(issue_valid_o), 0);
    chk("rst_instr", issue_instr_o, 0);
    chk("rst_busy", 32'(busy_o), 0);
    chk("rst_done", 32'(done_o), 0);
    chk("rst_stall", 32'(stall_cnt_o), 0);
    start_i = 1'b0;
    rst     = 1'b0;

    // Independent 4-word stream
    fill_indep(4);
    run_prog(3, 1'b0, 0);
    chk("indep_stall", 32'(stall_cnt_o), 0);

    // Back-to-back read-after-write
    mem[0] = mk(0, 4, 5, 0, 0, 0, 0);
    mem[1] = mk(1, 9, 10, 4, 0, 0, 0);
    run_prog(1, 1'b0, 0);
    chk("raw1_stall", 32'(stall_cnt_o), 2);

    // Distance-2 read-after-write through wd2
    mem[0] = mk(2, 8, 7, 0, 0, 0, 0);
    mem[1] = mk(0, 9, 10, 0, 0, 0, 0);
    mem[2] = mk(1, 11, 12, 0, 0, 0, 7);
    run_prog(2, 1'b0, 0);
    chk("raw2_stall", 32'(stall_cnt_o), 1);

    // Source equal to own destination must not stall
    mem[0] = mk(0, 3, 3, 3, 3, 3, 3);
    mem[1] = mk(0, 6, 6, 6, 0, 0, 0);
    run_prog(1, 1'b0, 0);
    chk("self_stall", 32'(stall_cnt_o), 0);

    // Full 32-word program, pc must stop at 31
    fill_indep(32);
    run_prog(31, 1'b0, 0);
    chk("full_pc", 32'(pc_o), 31);

    // Reset after the 5th issue, then a clean rerun
    fill_indep(10);
    run_prog(9, 1'b0, 5);
    run_prog(9, 1'b0, 0);

    // start toggling while busy must be ignored
    fill_random(10);
    run_prog(9, 1'b1, 0);

    // Random programs with a small register pool to provoke hazards
    for (int n = 0; n < 10; n++) begin
      int last;
      last = $urandom_range(0, 15);
      fill_random(last + 1);
      run_prog(last, n[0], 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
